// File: rtl/sng_pair_gen.sv
// ---------------------------------------------------------------------------
// sng_pair_gen
//   Dual stochastic number generator. Two BW-bit operands are converted into
//   two unary bitstreams of 2^BW valid cycles each. Both streams are driven by
//   a shared up-counter, so each conversion carries exactly the operand value
//   in ones. Stream 1 compares against the bit-reversed counter by default,
//   which decorrelates it from stream 0.
//
//   Optional build macro: SNG_PAIR_CORR_EN
//     defined   : stream 1 uses the plain counter (streams fully correlated)
//     undefined : stream 1 uses the bit-reversed counter (default)
//
// Parameters
//   BW     operand width; stream length is 2^BW valid cycles
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   conversion request, sampled only while idle
//   src0   in   operand 0, latched when start is accepted
//   src1   in   operand 1, latched when start is accepted
//   hold   in   stall while running: counter frozen, valid low
//   busy   out  high whenever a conversion is in progress (state != IDLE)
//   valid  out  out0/out1 carry a stream bit this cycle
//   out0   out  stream bit 0, P(1) = src0 / 2^BW
//   out1   out  stream bit 1, P(1) = src1 / 2^BW
//   done   out  one-cycle pulse in the cycle after the last stream bit
// ---------------------------------------------------------------------------
module sng_pair_gen #(
  parameter int unsigned BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [BW-1:0] src0,
  input  logic [BW-1:0] src1,
  input  logic          hold,
  output logic          busy,
  output logic          valid,
  output logic          out0,
  output logic          out1,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] cnt_q,   cnt_d;
  logic [BW-1:0] s0_q,    s0_d;
  logic [BW-1:0] s1_q,    s1_d;
  logic          wrap_q,  wrap_d;
  logic          valid_d, out0_d, out1_d, done_d;
  logic [BW-1:0] rng1;

  // Stream 1 random source.
  always_comb begin
    rng1 = '0;
`ifdef SNG_PAIR_CORR_EN
    rng1 = cnt_q;
`else
    for (int unsigned i = 0; i < BW; i++) begin
      rng1[i] = cnt_q[BW-1-i];
    end
`endif
  end

  // The last stream bit is registered on the edge where cnt wraps; wrap_q
  // remembers that so the following edge raises done while the FSM moves to
  // DONE. This keeps done one cycle after the last valid bit and keeps busy
  // high through the done cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    wrap_d  = wrap_q;
    valid_d = 1'b0;
    out0_d  = 1'b0;
    out1_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          s0_d    = src0;
          s1_d    = src1;
          cnt_d   = '0;
          wrap_d  = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (wrap_q) begin
          wrap_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (!hold) begin
          valid_d = 1'b1;
          out0_d  = (s0_q > cnt_q);
          out1_d  = (s1_q > rng1);
          cnt_d   = cnt_q + BW'(1);
          if (cnt_q == '1) begin
            wrap_d = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      wrap_q  <= 1'b0;
      valid   <= 1'b0;
      out0    <= 1'b0;
      out1    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      wrap_q  <= wrap_d;
      valid   <= valid_d;
      out0    <= out0_d;
      out1    <= out1_d;
      done    <= done_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sng_pair_gen.sv
// ---------------------------------------------------------------------------
// tb_sng_pair_gen
//   Scoreboard bench for sng_pair_gen. Stimulus pushes per-beat expected
//   stream bits plus hand-computed per-conversion totals; a monitor on the
//   falling edge pops and compares whenever valid or done is presented.
// ---------------------------------------------------------------------------
module tb_sng_pair_gen;

  localparam int BW  = 8;
  localparam int LEN = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          hold;
  logic [BW-1:0] src0;
  logic [BW-1:0] src1;
  logic          busy, valid, out0, out1, done;

  always #5 clk = ~clk;

  sng_pair_gen #(.BW(BW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .src0  (src0),
    .src1  (src1),
    .hold  (hold),
    .busy  (busy),
    .valid (valid),
    .out0  (out0),
    .out1  (out1),
    .done  (done)
  );

  typedef struct {
    int s0;
    int s1;
    int sa;
  } conv_t;

  conv_t      conv_q[$];
  logic [1:0] beat_q[$];

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int beat_cnt = 0;
  int acc0 = 0, acc1 = 0, acca = 0;
  logic prev_valid = 1'b0;
  logic prev_done  = 1'b0;

`ifdef SNG_PAIR_CORR_EN
  localparam bit CORR = 1'b1;
`else
  localparam bit CORR = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_rng1(input int i);
    int r;
    r = 0;
    if (CORR) begin
      r = i;
    end else begin
      for (int b = 0; b < BW; b++) begin
        if (((i >> b) & 1) != 0) r = r | (1 << (BW - 1 - b));
      end
    end
    return r;
  endfunction

  task automatic push_conv(input int a, input int b, input int e0, input int e1, input int ea);
    conv_t c;
    logic [1:0] v;
    for (int i = 0; i < LEN; i++) begin
      v[1] = (a > i);
      v[0] = (b > model_rng1(i));
      beat_q.push_back(v);
    end
    c.s0 = e0;
    c.s1 = e1;
    c.sa = ea;
    conv_q.push_back(c);
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [1:0] e;
    conv_t c;
    if (rst) begin
      acc0 = 0; acc1 = 0; acca = 0; beat_cnt = 0;
      prev_valid = 1'b0; prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        chk("busy_after_done", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);
      end
      if (valid) begin
        chk("busy_while_valid", int'(busy), 1);
        chk("beat_expected", int'(beat_q.size() > 0), 1);
        if (beat_q.size() > 0) begin
          e = beat_q.pop_front();
          chk("beat_out0", int'(out0), int'(e[1]));
          chk("beat_out1", int'(out1), int'(e[0]));
        end
        beat_cnt++;
        acc0 += int'(out0);
        acc1 += int'(out1);
        acca += int'(out0 & out1);
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last_valid", int'(prev_valid), 1);
        chk("busy_in_done", int'(busy), 1);
        chk("valid_in_done", int'(valid), 0);
        chk("done_expected", int'(conv_q.size() > 0), 1);
        if (conv_q.size() > 0) begin
          c = conv_q.pop_front();
          chk("valid_beats", beat_cnt, LEN);
          chk("sum_out0", acc0, c.s0);
          chk("sum_out1", acc1, c.s1);
          chk("sum_and", acca, c.sa);
          chk("beats_left", beat_q.size(), 0);
        end
        acc0 = 0; acc1 = 0; acca = 0; beat_cnt = 0;
      end
      prev_valid = valid;
      prev_done  = done;
    end
  end

  // Caller is just after a rising edge; start is accepted on the next edge.
  task automatic do_start(input logic [7:0] a, input logic [7:0] b);
    #1;
    src0  = a;
    src1  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    src0  = ~a;
    src1  = ~b;
    chk("busy_after_start", int'(busy), 1);
    chk("valid_latency", int'(valid), 0);
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (done_cnt == prev && n < 600) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", int'(done_cnt > prev), 1);
  endtask

  task automatic run_conv(input logic [7:0] a, input logic [7:0] b,
                          input int e0, input int e1, input int ea);
    int prev;
    prev = done_cnt;
    push_conv(int'(a), int'(b), e0, e1, ea);
    @(posedge clk);
    do_start(a, b);
    @(posedge clk);
    #1;
    chk("first_valid", int'(valid), 1);
    wait_done(prev);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int prev;
    int saved;
    int n;
    rst = 1'b1; start = 1'b0; hold = 1'b0; src0 = '0; src1 = '0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_out0", int'(out0), 0);
    chk("rst_out1", int'(out1), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1: 0x40 / 0xC0
    run_conv(8'h40, 8'hC0, 64, 192, CORR ? 64 : 48);
    // 2: extremes
    run_conv(8'h00, 8'hFF, 0, 255, 0);
    // 3: half / half
    run_conv(8'h80, 8'h80, 128, 128, CORR ? 128 : 64);

    // 4: hold pattern
    prev = done_cnt;
    push_conv(8'h33, 8'h00, 51, 0, 0);
    @(posedge clk);
    do_start(8'h33, 8'h00);
    repeat (49) @(posedge clk);
    #1; hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("valid_low_in_hold", int'(valid), 0);
    end
    hold = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (7) @(posedge clk);
      #1; hold = 1'b1;
      @(posedge clk); #1;
      chk("valid_low_single_hold", int'(valid), 0);
      hold = 1'b0;
    end
    wait_done(prev);

    // 5: start during RUN ignored, start right after done accepted
    prev = done_cnt;
    push_conv(8'h40, 8'hC0, 64, 192, CORR ? 64 : 48);
    @(posedge clk);
    do_start(8'h40, 8'hC0);
    repeat (20) @(posedge clk);
    #1; src0 = 8'h11; src1 = 8'h22; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(prev);
    prev = done_cnt;
    push_conv(8'hFF, 8'h01, 255, 1, 1);
    do_start(8'hFF, 8'h01);
    wait_done(prev);

    // 6: reset mid-run
    push_conv(8'h40, 8'hC0, 64, 192, CORR ? 64 : 48);
    @(posedge clk);
    do_start(8'h40, 8'hC0);
    n = 0;
    while (beat_cnt < 100 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("reached_beat_100", int'(beat_cnt >= 100), 1);
    saved = done_cnt;
    #2; rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_out0", int'(out0), 0);
    chk("midrst_out1", int'(out1), 0);
    chk("midrst_done", int'(done), 0);
    conv_q.delete();
    beat_q.delete();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (20) @(posedge clk);
    chk("no_done_after_reset", done_cnt, saved);
    run_conv(8'h10, 8'h20, 16, 32, CORR ? 16 : 2);

    repeat (5) @(posedge clk);
    chk("conv_queue_empty", conv_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
